regfile_writeback: RTL

Writeback buffer between the ALU and the register file. Accepts ALU results tagged with a `write_sel_t` code and holds them in a small FIFO. Drains one register write per granted cycle into the register file's single write port. Publishes a pending-write scoreboard so decode can stall on read-after-write hazards.

---
 rtl/regfile_writeback.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Writeback buffer between the ALU and the register file: small in-order FIFO feeding the single
// RF write port, plus a pending-write scoreboard. Optional forwarding tap via REGFILE_WB_FWD_EN.
module regfile_writeback #(
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH       = 2,
   parameter int INDEX_WIDTH = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [1:0]                    in_wsel,
   input  logic [INDEX_WIDTH-1:0]        in_dest,
   input  logic [DATA_WIDTH-1:0]         in_result,
   input  logic [DATA_WIDTH-1:0]         in_flags,
   output logic                          rf_we,
   output logic [INDEX_WIDTH-1:0]        rf_waddr,
   output logic [DATA_WIDTH-1:0]         rf_wdata,
   input  logic                          rf_wgrant,
   output logic [(1<<INDEX_WIDTH)-1:0]   pending,
   output logic [$clog2(DEPTH):0]        occupancy,
   output logic                          err_rfu
`ifdef REGFILE_WB_FWD_EN
   ,
   output logic                          fwd_valid,
   output logic [INDEX_WIDTH-1:0]        fwd_addr,
   output logic [DATA_WIDTH-1:0]         fwd_data
`endif
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int NREG  = 1 << INDEX_WIDTH;

   localparam logic [1:0] WSEL_NONE = 2'b00;
   localparam logic [1:0] WSEL_REGC = 2'b01;
   localparam logic [1:0] WSEL_REGF = 2'b10;
   localparam logic [1:0] WSEL_RFU  = 2'b11;

   localparam logic [INDEX_WIDTH-1:0] R_ZERO = '0;
   localparam logic [INDEX_WIDTH-1:0] R_F    = '1;

   // Control state
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic             err_rfu_q, err_rfu_d;

   // Entry storage (data path, not reset)
   logic [INDEX_WIDTH-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0]  data_q [DEPTH];

   logic [IDX_W-1:0]       wr_idx, rd_idx;
   logic                   full, empty;
   logic                   accept, push, pop;
   logic [INDEX_WIDTH-1:0] new_addr;
   logic [DATA_WIDTH-1:0]  new_data;
   logic [NREG-1:0]        pend;

   function automatic logic entry_kept(input logic [1:0] wsel, input logic [INDEX_WIDTH-1:0] dest);
      logic kept;
      kept = 1'b0;
      case (wsel)
         WSEL_REGC: kept = (dest != R_ZERO);
         WSEL_REGF: kept = 1'b1;
         default:   kept = 1'b0;
      endcase
      return kept;
   endfunction

   function automatic logic [INDEX_WIDTH-1:0] entry_addr(input logic [1:0] wsel,
                                                         input logic [INDEX_WIDTH-1:0] dest);
      return (wsel == WSEL_REGF) ? R_F : dest;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] entry_data(input logic [1:0] wsel,
                                                        input logic [DATA_WIDTH-1:0] result,
                                                        input logic [DATA_WIDTH-1:0] flags);
      return (wsel == WSEL_REGF) ? flags : result;
   endfunction

   assign wr_idx = wr_ptr_q[IDX_W-1:0];
   assign rd_idx = rd_ptr_q[IDX_W-1:0];
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

   // in_ready depends on state only; a full buffer never accepts, even on a same-cycle pop
   assign in_ready = !full;
   assign accept   = in_valid && in_ready;
   assign push     = accept && entry_kept(in_wsel, in_dest);
   assign pop      = rf_we && rf_wgrant;

   assign new_addr = entry_addr(in_wsel, in_dest);
   assign new_data = entry_data(in_wsel, in_result, in_flags);

   assign rf_we     = !empty;
   assign rf_waddr  = empty ? '0 : addr_q[rd_idx];
   assign rf_wdata  = empty ? '0 : data_q[rd_idx];
   assign occupancy = wr_ptr_q - rd_ptr_q;
   assign err_rfu   = err_rfu_q;

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i]) begin
            pend = pend | (NREG'(1) << addr_q[i]);
         end
      end
      pend[0] = 1'b0;
   end
   assign pending = pend;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      vld_d     = vld_q;
      err_rfu_d = err_rfu_q;
      if (pop) begin
         rd_ptr_d       = rd_ptr_q + PTR_W'(1);
         vld_d[rd_idx]  = 1'b0;
      end
      if (push) begin
         wr_ptr_d       = wr_ptr_q + PTR_W'(1);
         vld_d[wr_idx]  = 1'b1;
      end
      if (accept && (in_wsel == WSEL_RFU)) begin
         err_rfu_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         vld_q     <= '0;
         err_rfu_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         vld_q     <= vld_d;
         err_rfu_q <= err_rfu_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_idx] <= new_addr;
         data_q[wr_idx] <= new_data;
      end
   end

`ifdef REGFILE_WB_FWD_EN
   // Youngest entry sits one slot behind the write pointer
   logic [IDX_W-1:0] yng_idx;
   assign yng_idx   = wr_idx - IDX_W'(1);
   assign fwd_valid = !empty;
   assign fwd_addr  = empty ? '0 : addr_q[yng_idx];
   assign fwd_data  = empty ? '0 : data_q[yng_idx];
`endif

   logic unused_ok;
   assign unused_ok = (WSEL_NONE == 2'b00);

endmodule
